// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key codes and the key map.
// The KEY_* codes are also consumed by the calculator input controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_e;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    // Indexed by row*4 + col
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, KEY_ADD,
        4'h4, 4'h5, 4'h6, KEY_SUB,
        4'h7, 4'h8, 4'h9, KEY_MUL,
        KEY_CLR, 4'h0, KEY_EQ, KEY_DIV
    };

    function automatic logic single_low(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        case (r)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Parameterised-width two-flop synchronizer; resets to all-ones (idle, pulled-up rows).
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates an active-low column drive, debounces press and release,
// and presents a held key code plus a level flag that rises once per press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int SCAN_DWELL      = 4
) (
    input  logic       CLK_1K,
    input  logic       RST,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value,
    output logic       flag
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = $clog2(SCAN_DWELL);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] PRESS_MIN  = CW'(2);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);

    logic [3:0]    row_s;
    state_e        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cap_row_q, cap_row_d;
    logic [3:0]    cap_idx_q, cap_idx_d;
    logic [3:0]    key_q, key_d;
    logic          flag_q, flag_d;

    sync2 #(.WIDTH(4)) u_sync2 (
        .clk   (CLK_1K),
        .rst_n (RST),
        .d     (row),
        .q     (row_s)
    );

    always_ff @(posedge CLK_1K or negedge RST) begin
        if (!RST) begin
            state_q   <= SCAN;
            col_idx_q <= '0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            cap_row_q <= '1;
            cap_idx_q <= '0;
            key_q     <= '0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            cap_row_q <= cap_row_d;
            cap_idx_q <= cap_idx_d;
            key_q     <= key_d;
            flag_q    <= flag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        cap_row_d = cap_row_q;
        cap_idx_d = cap_idx_q;
        key_d     = key_q;
        flag_d    = 1'b0;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (single_low(row_s)) begin
                        cap_row_d = row_s;
                        cap_idx_d = {low_index(row_s), col_idx_q};
                        cnt_d     = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s == cap_row_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        key_d   = KEYMAP[cap_idx_q];
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end
                end else begin
                    cnt_d     = '0;
                    dwell_d   = '0;
                    col_idx_d = col_idx_q + 1'b1;
                    state_d   = SCAN;
                end
            end
            // flag lags state entry by a cycle, so the exit gate waits for two flag-high cycles
            PRESSED: begin
                flag_d = 1'b1;
                cnt_d  = cnt_inc;
                if ((cnt_q >= PRESS_MIN) && (row_s == 4'hF)) begin
                    flag_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (row_s == 4'hF) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        cnt_d     = '0;
                        dwell_d   = '0;
                        col_idx_d = col_idx_q + 1'b1;
                        state_d   = SCAN;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        col       = ~(4'b0001 << col_idx_q);
        key_value = key_q;
        flag      = flag_q;
    end

endmodule
